// File: rtl/rv_branch_pkg.sv
// Shared types and funct3 encodings for the branch predict/resolve unit.
package rv_branch_pkg;

   localparam int BP_XLEN = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] ctr2_t;

   typedef struct packed {
      logic               valid;
      logic [BP_XLEN-1:0] tag;
      logic [BP_XLEN-1:0] target;
      ctr2_t              ctr;
   } btb_entry_t;

   localparam ctr2_t CTR_MAX   = 2'd3;
   localparam ctr2_t CTR_MIN   = 2'd0;
   localparam ctr2_t CTR_RESET = 2'd1;

endpackage

// File: rtl/branch_predict_resolve_unit_sat_counter.sv
// 2-bit saturating up/down counter next-value logic, one per BTB entry.
module branch_sat_counter
   import rv_branch_pkg::*;
(
   input  ctr2_t ctr_i,
   input  logic  up_i,
   output ctr2_t ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (up_i) begin
         if (ctr_i != CTR_MAX) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_MIN) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predict_resolve_unit.sv
// Branch/jump unit: BTB lookup in IF, resolution, redirect and BTB update in EX.
// Optional perf counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_resolve_unit
   import rv_branch_pkg::*;
#(
   parameter int XLEN        = BP_XLEN,
   parameter int BTB_ENTRIES = 16,
   parameter int CTR_ALLOC   = 2
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [XLEN-1:0] IF_PC,
   output logic            PRED_TAKEN,
   output logic [XLEN-1:0] PRED_TARGET,
   input  logic            EX_VALID,
   input  logic [XLEN-1:0] EX_PC,
   input  logic            EX_BRANCH,
   input  logic            EX_JUMP,
   input  logic [2:0]      EX_FUNCT3,
   input  logic [XLEN-1:0] EX_BRANCH_IMM,
   input  logic [XLEN-1:0] EX_JUMP_TARGET,
   input  logic            ZERO,
   input  logic            SIGN,
   input  logic            SLTU,
   input  logic            EX_PRED_TAKEN,
   input  logic [XLEN-1:0] EX_PRED_TARGET,
   output logic            REDIRECT,
   output logic [XLEN-1:0] REDIRECT_PC,
`ifdef BRANCH_PERF_CNT_EN
   output logic [31:0]     PERF_BRANCHES,
   output logic [31:0]     PERF_MISPREDICTS,
`endif
   output logic            FLUSH
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);

   btb_entry_t btb_q [BTB_ENTRIES];
   btb_entry_t btb_d [BTB_ENTRIES];
   ctr2_t      ctr_nxt [BTB_ENTRIES];

   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [XLEN-1:0]  if_tag, ex_tag;
   logic             if_hit, ex_hit;

   logic            active, is_jump, is_branch;
   logic            cond, f3_ok, taken, mispredict;
   logic [XLEN-1:0] target, seq_pc;

   // Tags keep the full shifted PC; the upper zero bits fold away.
   assign if_idx = IF_PC[IDX_W+1:2];
   assign ex_idx = EX_PC[IDX_W+1:2];
   assign if_tag = IF_PC >> (IDX_W + 2);
   assign ex_tag = EX_PC >> (IDX_W + 2);

   assign if_hit = btb_q[if_idx].valid && (btb_q[if_idx].tag == if_tag);
   assign ex_hit = btb_q[ex_idx].valid && (btb_q[ex_idx].tag == ex_tag);

   assign PRED_TAKEN  = if_hit && btb_q[if_idx].ctr[1];
   assign PRED_TARGET = if_hit ? btb_q[if_idx].target : IF_PC + XLEN'(4);

   always_comb begin
      cond  = 1'b0;
      f3_ok = 1'b1;
      case (EX_FUNCT3)
         F3_BEQ:  cond = ZERO;
         F3_BNE:  cond = ~ZERO;
         F3_BLT:  cond = SIGN;
         F3_BGE:  cond = ~SIGN;
         F3_BLTU: cond = SLTU;
         F3_BGEU: cond = ~SLTU;
         default: f3_ok = 1'b0;
      endcase
   end

   // Wrong-path instruction in the redirect cycle is ignored.
   assign active    = EX_VALID && !redirect_q;
   assign is_jump   = EX_JUMP;
   assign is_branch = EX_BRANCH && !EX_JUMP;
   assign taken     = is_jump || (is_branch && cond);
   assign seq_pc    = EX_PC + XLEN'(4);
   assign target    = is_jump ? EX_JUMP_TARGET
                              : EX_PC + EX_BRANCH_IMM;

   assign mispredict =
      (taken && (!EX_PRED_TAKEN || (EX_PRED_TARGET != target))) ||
      (!taken && EX_PRED_TAKEN);

   for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_ctr
      branch_sat_counter u_ctr (
         .ctr_i (btb_q[i].ctr),
         .up_i  (taken),
         .ctr_o (ctr_nxt[i])
      );
   end

   always_comb begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (active && mispredict) begin
         redirect_d    = 1'b1;
         redirect_pc_d = taken ? target : seq_pc;
      end
   end

   always_comb begin
      btb_d = btb_q;
      if (active) begin
         if (is_jump) begin
            btb_d[ex_idx].valid  = 1'b1;
            btb_d[ex_idx].tag    = ex_tag;
            btb_d[ex_idx].target = target;
            btb_d[ex_idx].ctr    = CTR_MAX;
         end else if (is_branch && f3_ok) begin
            if (ex_hit) begin
               btb_d[ex_idx].ctr = ctr_nxt[ex_idx];
               if (taken) btb_d[ex_idx].target = target;
            end else if (taken) begin
               btb_d[ex_idx].valid  = 1'b1;
               btb_d[ex_idx].tag    = ex_tag;
               btb_d[ex_idx].target = target;
               btb_d[ex_idx].ctr    = ctr2_t'(CTR_ALLOC);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_q[i].valid  <= 1'b0;
            btb_q[i].tag    <= '0;
            btb_q[i].target <= '0;
            btb_q[i].ctr    <= CTR_RESET;
         end
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_q[i] <= btb_d[i];
         end
      end
   end

   assign REDIRECT    = redirect_q;
   assign FLUSH       = redirect_q;
   assign REDIRECT_PC = redirect_pc_q;

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_br_d;
   logic [31:0] perf_mis_q, perf_mis_d;

   always_comb begin
      perf_br_d  = perf_br_q;
      perf_mis_d = perf_mis_q;
      if (active && (perf_br_q != '1)) perf_br_d = perf_br_q + 32'd1;
      if (redirect_d && (perf_mis_q != '1)) perf_mis_d = perf_mis_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         perf_br_q  <= '0;
         perf_mis_q <= '0;
      end else begin
         perf_br_q  <= perf_br_d;
         perf_mis_q <= perf_mis_d;
      end
   end

   assign PERF_BRANCHES    = perf_br_q;
   assign PERF_MISPREDICTS = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Scoreboard bench for branch_predict_resolve_unit (default 16-entry BTB).
module tb_branch_predict_resolve_unit;
   import rv_branch_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] IF_PC;
   logic        PRED_TAKEN;
   logic [31:0] PRED_TARGET;
   logic        EX_VALID, EX_BRANCH, EX_JUMP;
   logic [31:0] EX_PC, EX_BRANCH_IMM, EX_JUMP_TARGET;
   logic [2:0]  EX_FUNCT3;
   logic        ZERO, SIGN, SLTU;
   logic        EX_PRED_TAKEN;
   logic [31:0] EX_PRED_TARGET;
   logic        REDIRECT, FLUSH;
   logic [31:0] REDIRECT_PC;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] PERF_BRANCHES, PERF_MISPREDICTS;
`endif

   branch_predict_resolve_unit dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .IF_PC          (IF_PC),
      .PRED_TAKEN     (PRED_TAKEN),
      .PRED_TARGET    (PRED_TARGET),
      .EX_VALID       (EX_VALID),
      .EX_PC          (EX_PC),
      .EX_BRANCH      (EX_BRANCH),
      .EX_JUMP        (EX_JUMP),
      .EX_FUNCT3      (EX_FUNCT3),
      .EX_BRANCH_IMM  (EX_BRANCH_IMM),
      .EX_JUMP_TARGET (EX_JUMP_TARGET),
      .ZERO           (ZERO),
      .SIGN           (SIGN),
      .SLTU           (SLTU),
      .EX_PRED_TAKEN  (EX_PRED_TAKEN),
      .EX_PRED_TARGET (EX_PRED_TARGET),
      .REDIRECT       (REDIRECT),
      .REDIRECT_PC    (REDIRECT_PC),
`ifdef BRANCH_PERF_CNT_EN
      .PERF_BRANCHES    (PERF_BRANCHES),
      .PERF_MISPREDICTS (PERF_MISPREDICTS),
`endif
      .FLUSH          (FLUSH)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
   } red_t;

   typedef struct {
      int          cyc;
      logic        tk;
      logic [31:0] tg;
   } pred_t;

   red_t  red_q [$];
   pred_t pred_q [$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares every cycle against what the stimulus queued.
   always @(negedge CLK) begin
      if (RESET_N === 1'b1) begin
         logic exp_red;
         while (red_q.size() > 0 && red_q[0].cyc < cyc) begin
            chk("redirect_missing", 32'(red_q[0].cyc), 32'(cyc));
            void'(red_q.pop_front());
         end
         exp_red = (red_q.size() > 0) && (red_q[0].cyc == cyc);
         chk("redirect", 32'(REDIRECT), 32'(exp_red));
         chk("flush", 32'(FLUSH), 32'(exp_red));
         if (exp_red) begin
            red_t r;
            r = red_q.pop_front();
            chk("redirect_pc", REDIRECT_PC, r.pc);
         end
         while (pred_q.size() > 0 && pred_q[0].cyc <= cyc) begin
            pred_t p;
            p = pred_q.pop_front();
            if (p.cyc < cyc) begin
               chk("pred_stale", 32'(p.cyc), 32'(cyc));
            end else begin
               chk("pred_taken", 32'(PRED_TAKEN), 32'(p.tk));
               chk("pred_target", PRED_TARGET, p.tg);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ex_clr();
      EX_VALID       = 1'b0;
      EX_BRANCH      = 1'b0;
      EX_JUMP        = 1'b0;
      EX_PC          = '0;
      EX_FUNCT3      = '0;
      EX_BRANCH_IMM  = '0;
      EX_JUMP_TARGET = '0;
      ZERO           = 1'b0;
      SIGN           = 1'b0;
      SLTU           = 1'b0;
      EX_PRED_TAKEN  = 1'b0;
      EX_PRED_TARGET = '0;
   endtask

   task automatic cb();
      tick();
      ex_clr();
   endtask

   task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                     input logic [31:0] imm, input logic z,
                     input logic s, input logic u, input logic pt,
                     input logic [31:0] ptg);
      EX_VALID       = 1'b1;
      EX_BRANCH      = 1'b1;
      EX_PC          = pc;
      EX_FUNCT3      = f3;
      EX_BRANCH_IMM  = imm;
      ZERO           = z;
      SIGN           = s;
      SLTU           = u;
      EX_PRED_TAKEN  = pt;
      EX_PRED_TARGET = ptg;
   endtask

   task automatic jal(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptg,
                      input logic also_br);
      EX_VALID       = 1'b1;
      EX_JUMP        = 1'b1;
      EX_BRANCH      = also_br;
      EX_FUNCT3      = F3_BEQ;
      EX_PC          = pc;
      EX_JUMP_TARGET = tgt;
      EX_PRED_TAKEN  = pt;
      EX_PRED_TARGET = ptg;
   endtask

   task automatic look(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg);
      IF_PC = pc;
      pred_q.push_back('{cyc: cyc, tk: tk, tg: tg});
   endtask

   task automatic exp_red(input logic [31:0] pc);
      red_q.push_back('{cyc: cyc + 1, pc: pc});
   endtask

   initial begin
      RESET_N = 1'b0;
      IF_PC   = '0;
      ex_clr();
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_redirect", 32'(REDIRECT), 32'd0);
      chk("rst_flush", 32'(FLUSH), 32'd0);
      chk("rst_redirect_pc", REDIRECT_PC, 32'h0);
      RESET_N = 1'b1;

      // empty BTB
      cb(); look(32'h100, 1'b0, 32'h104);
      cb(); look(32'h100, 1'b0, 32'h104);

      // beq taken, predicted not-taken; lookup same cycle sees old contents
      cb(); br(32'h100, F3_BEQ, 32'h40, 1, 0, 0, 0, 0);
      exp_red(32'h140); look(32'h100, 1'b0, 32'h104);
      cb(); look(32'h100, 1'b1, 32'h140);

      // beq not taken while predicted taken
      cb(); br(32'h100, F3_BEQ, 32'h40, 0, 0, 0, 1, 32'h140);
      exp_red(32'h104); look(32'h100, 1'b1, 32'h140);
      cb(); look(32'h100, 1'b0, 32'h140);
      cb(); br(32'h100, F3_BEQ, 32'h40, 0, 0, 0, 0, 0);
      look(32'h100, 1'b0, 32'h140);
      cb(); br(32'h100, F3_BEQ, 32'h40, 0, 0, 0, 0, 0);
      look(32'h100, 1'b0, 32'h140);
      cb(); look(32'h100, 1'b0, 32'h140);
      cb(); br(32'h100, F3_BEQ, 32'h40, 1, 0, 0, 0, 0);
      exp_red(32'h140);
      cb(); look(32'h100, 1'b0, 32'h140);

      // JAL correct, then wrong target (branch flag also set)
      cb(); jal(32'h200, 32'h80, 1, 32'h80, 0);
      look(32'h200, 1'b0, 32'h204);
      cb(); look(32'h200, 1'b1, 32'h80);
      cb(); look(32'h100, 1'b0, 32'h104);
      cb(); jal(32'h200, 32'h80, 1, 32'h90, 1);
      exp_red(32'h80);
      cb(); look(32'h200, 1'b1, 32'h80);

      // instruction in redirect cycle is squashed
      cb(); br(32'h108, F3_BNE, 32'h20, 0, 0, 0, 0, 0);
      exp_red(32'h128); look(32'h108, 1'b0, 32'h10C);
      cb(); br(32'h10C, F3_BLT, 32'h10, 0, 1, 0, 0, 0);
      look(32'h108, 1'b1, 32'h128);
      cb(); look(32'h10C, 1'b0, 32'h110);

      // remaining funct3 encodings
      cb(); br(32'h180, F3_BGEU, 32'hFFFF_FF80, 0, 0, 0, 0, 0);
      exp_red(32'h100);
      cb(); look(32'h180, 1'b1, 32'h100);
      cb(); br(32'h184, F3_BLTU, 32'h40, 0, 0, 0, 1, 32'h1C4);
      exp_red(32'h188); look(32'h184, 1'b0, 32'h188);
      cb();
      cb(); br(32'h18C, 3'b010, 32'h40, 1, 1, 1, 0, 0);
      cb(); br(32'h190, F3_BGE, 32'h40, 0, 1, 0, 0, 0);
      look(32'h18C, 1'b0, 32'h190);
      cb(); br(32'h194, F3_BGE, 32'h8, 0, 0, 0, 1, 32'h19C);
      look(32'h190, 1'b0, 32'h194);
      cb(); look(32'h194, 1'b1, 32'h19C);

      // aliasing on idx 0
      cb(); br(32'h100, F3_BEQ, 32'h40, 1, 0, 0, 0, 0);
      exp_red(32'h140);
      cb(); look(32'h100, 1'b1, 32'h140);
      cb(); br(32'h140, F3_BEQ, 32'h10, 1, 0, 0, 0, 0);
      exp_red(32'h150);
      cb(); look(32'h100, 1'b0, 32'h104);
      cb(); look(32'h140, 1'b1, 32'h150);

      // reset asserted during a redirect pulse
      cb(); jal(32'h300, 32'h400, 0, 0, 0);
      tick();
      chk("mid_redirect_pre", 32'(REDIRECT), 32'd1);
      chk("mid_redirect_pc_pre", REDIRECT_PC, 32'h400);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_redirect", 32'(REDIRECT), 32'd0);
      chk("mid_rst_flush", 32'(FLUSH), 32'd0);
      chk("mid_rst_redirect_pc", REDIRECT_PC, 32'h0);
      ex_clr();
      repeat (2) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      look(32'h140, 1'b0, 32'h144);
      cb();
      cb();
      cb();

      chk("red_q_drained", 32'(red_q.size()), 32'd0);
      chk("pred_q_drained", 32'(pred_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
